// File: rtl/watch_pkg.sv
// Shared watch definitions: field select encodings, field ranges and widths.
// Used by the control unit, this datapath and the FND formatter.
package watch_pkg;

    typedef enum logic [1:0] {
        TIME_MSEC = 2'd0,
        TIME_SEC  = 2'd1,
        TIME_MIN  = 2'd2,
        TIME_HOUR = 2'd3
    } time_sel_e;

    localparam int unsigned MSEC_MAX = 99;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned MSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam int unsigned FIELD_N    = 4;
    localparam int unsigned BLINK_W    = 5;
    localparam int unsigned BLINK_WRAP = 24;

    // One-hot field mask, bit0 msec .. bit3 hour.
    function automatic logic [FIELD_N-1:0] sel_onehot(input logic [1:0] sel);
        sel_onehot = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/watch_field_cnt.sv
// Modulo-(MAX+1) field counter: manual up/dn step has priority over the time-base inc.
// carry_c fires only when an inc wraps MAX back to 0.
module watch_field_cnt #(
    parameter int unsigned MAX = 59,
    parameter int unsigned W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] q,
    output logic         carry_c
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic         at_max;
    logic         at_zero;
    logic [W-1:0] q_next;

    assign at_max  = (q == MAX_V);
    assign at_zero = (q == '0);
    assign carry_c = inc & ~up & ~dn & at_max;

    always_comb begin
        q_next = q;
        if (up) begin
            q_next = at_max ? '0 : q + W'(1);
        end else if (dn) begin
            q_next = at_zero ? MAX_V : q - W'(1);
        end else if (inc) begin
            q_next = at_max ? '0 : q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/watch_dp.sv
// Watch timekeeping datapath: free-running hh:mm:ss.cc clock with one-step field adjust.
// Optional display blink of the selected field when WATCH_BLINK_EN is defined.
module watch_dp
    import watch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_time_select,
    input  logic [1:0]  i_up_down,
    output logic [6:0]  o_msec,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [4:0]  o_hour,
    output logic [3:0]  o_blink_mask
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0]   prescaler;
    logic               tick;
    logic               tick_pending;
    logic               prev_up;
    logic               prev_dn;
    logic               up_edge;
    logic               dn_edge;
    logic               any_edge;
    logic               adj_up;
    logic               adj_dn;
    logic               advance;
    logic [FIELD_N-1:0] sel_oh;
    logic [FIELD_N-1:0] step_up;
    logic [FIELD_N-1:0] step_dn;
    logic               msec_carry;
    logic               sec_carry;
    logic               min_carry;
    logic               hour_carry;

    assign tick = (prescaler == PRE_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        end
    end

    // Button edge detection; inputs are already debounced and synchronous.
    assign up_edge  = i_up_down[1] & ~prev_up;
    assign dn_edge  = i_up_down[0] & ~prev_dn;
    assign any_edge = up_edge | dn_edge;
    assign adj_up   = up_edge & ~dn_edge;
    assign adj_dn   = dn_edge & ~up_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_up <= 1'b0;
            prev_dn <= 1'b0;
        end else begin
            prev_up <= i_up_down[1];
            prev_dn <= i_up_down[0];
        end
    end

    // Any button-edge cycle holds every field still, so a coinciding tick waits a cycle.
    assign advance = (tick | tick_pending) & ~any_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_pending <= 1'b0;
        end else begin
            tick_pending <= (tick | tick_pending) & any_edge;
        end
    end

    assign sel_oh  = sel_onehot(i_time_select);
    assign step_up = sel_oh & {FIELD_N{adj_up}};
    assign step_dn = sel_oh & {FIELD_N{adj_dn}};

    watch_field_cnt #(.MAX(MSEC_MAX), .W(MSEC_W)) u_msec (
        .clk     (clk),
        .rst     (rst),
        .inc     (advance),
        .up      (step_up[TIME_MSEC]),
        .dn      (step_dn[TIME_MSEC]),
        .q       (o_msec),
        .carry_c (msec_carry)
    );

    watch_field_cnt #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk     (clk),
        .rst     (rst),
        .inc     (msec_carry),
        .up      (step_up[TIME_SEC]),
        .dn      (step_dn[TIME_SEC]),
        .q       (o_sec),
        .carry_c (sec_carry)
    );

    watch_field_cnt #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc     (sec_carry),
        .up      (step_up[TIME_MIN]),
        .dn      (step_dn[TIME_MIN]),
        .q       (o_min),
        .carry_c (min_carry)
    );

    // Hour wraps silently; its carry has no consumer.
    watch_field_cnt #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk     (clk),
        .rst     (rst),
        .inc     (min_carry),
        .up      (step_up[TIME_HOUR]),
        .dn      (step_dn[TIME_HOUR]),
        .q       (o_hour),
        .carry_c (hour_carry)
    );

`ifdef WATCH_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Phase flips every BLINK_WRAP+1 ticks; a press restarts it so the field shows at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (any_edge) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (advance) begin
            if (blink_cnt == BLINK_W'(BLINK_WRAP)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_blink_mask <= '0;
        end else begin
            o_blink_mask <= sel_oh & {FIELD_N{blink_phase}};
        end
    end
`else
    assign o_blink_mask = '0;
`endif

endmodule

// File: tb/tb_watch_dp.sv
// Directed scoreboard bench for watch_dp with DIV=10 (1 kHz clock, 100 Hz tick).
module tb_watch_dp;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_time_select;
    logic [1:0] i_up_down;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic [3:0] o_blink_mask;

`ifdef WATCH_BLINK_EN
    localparam logic [3:0] BLINK_SEC = 4'b0010;
`else
    localparam logic [3:0] BLINK_SEC = 4'b0000;
`endif

    always #5 clk = ~clk;

    watch_dp #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_time_select (i_time_select),
        .i_up_down     (i_up_down),
        .o_msec        (o_msec),
        .o_sec         (o_sec),
        .o_min         (o_min),
        .o_hour        (o_hour),
        .o_blink_mask  (o_blink_mask)
    );

    typedef struct {
        string       tag;
        logic [27:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [27:0] pack_time(input int h, input int m, input int s,
                                              input int ms, input logic [3:0] mask);
        return {5'(h), 6'(m), 6'(s), 7'(ms), mask};
    endfunction

    task automatic sb_push(input string tag, input int h, input int m, input int s,
                           input int ms, input logic [3:0] mask);
        exp_t e;
        e.tag = tag;
        e.val = pack_time(h, m, s, ms, mask);
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t        e;
        logic [27:0] obs;
        obs = {o_hour, o_min, o_sec, o_msec, o_blink_mask};
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed output with no expectation queued");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0d:%0d:%0d.%0d mask=%b, expected %0d:%0d:%0d.%0d mask=%b",
                   e.tag, obs[27:23], obs[22:17], obs[16:11], obs[10:4], obs[3:0],
                   e.val[27:23], e.val[22:17], e.val[16:11], e.val[10:4], e.val[3:0]);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [1:0] ud, input logic [1:0] sel, input int n);
        i_up_down     = ud;
        i_time_select = sel;
        clk_n(n);
    endtask

    task automatic step_chk(input logic [1:0] ud, input logic [1:0] sel, input int n,
                            input string tag, input int h, input int m, input int s,
                            input int ms, input logic [3:0] mask);
        i_up_down     = ud;
        i_time_select = sel;
        sb_push(tag, h, m, s, ms, mask);
        clk_n(n);
        sb_check();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input logic [1:0] ud, input logic [1:0] sel, input string tag);
        @(negedge clk);
        i_up_down     = ud;
        i_time_select = sel;
        rst           = 1'b1;
        sb_push(tag, 0, 0, 0, 0, 4'b0000);
        #1;
        sb_check();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // A new tick must never land while one is still pending.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert (!(dut.tick && dut.tick_pending)) else begin
                miscompares++;
                $error("FAIL tick_overlap: observed tick=1 pending=1, expected pending=0");
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        i_up_down     = 2'b00;
        i_time_select = 2'b00;
        clk_n(2);

        // Reset state and first tick
        do_reset(2'b00, 2'd0, "reset_state");
        step_chk(2'b00, 2'd0, 9, "pre_first_tick", 0, 0, 0, 0, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "first_tick", 0, 0, 0, 1, 4'b0000);

        // Adjust with wrap, no neighbour carry/borrow
        do_reset(2'b00, 2'd3, "rst_adj");
        step_chk(2'b01, 2'd3, 1, "hour_dn_wrap", 23, 0, 0, 0, 4'b0000);
        step(2'b00, 2'd3, 1);
        step_chk(2'b01, 2'd1, 1, "sec_dn_wrap", 23, 0, 59, 0, 4'b0000);
        step(2'b00, 2'd1, 1);
        step_chk(2'b10, 2'd1, 1, "sec_up_wrap", 23, 0, 0, 0, 4'b0000);
        step(2'b00, 2'd1, 1);
        step_chk(2'b10, 2'd3, 1, "hour_up_wrap", 0, 0, 0, 0, 4'b0000);
        step(2'b00, 2'd3, 2);
        step_chk(2'b00, 2'd3, 1, "tick_after_adj", 0, 0, 0, 1, 4'b0000);

        // Held button steps once
        do_reset(2'b00, 2'd2, "rst_held");
        step_chk(2'b10, 2'd2, 1, "held_first", 0, 1, 0, 0, 4'b0000);
        step_chk(2'b10, 2'd2, 49, "held_50", 0, 1, 0, 5, 4'b0000);
        step(2'b00, 2'd2, 1);

        // Simultaneous edges do nothing; edge registers still track
        do_reset(2'b00, 2'd2, "rst_sim");
        step_chk(2'b11, 2'd2, 1, "both_edges", 0, 0, 0, 0, 4'b0000);
        step_chk(2'b11, 2'd2, 1, "both_held", 0, 0, 0, 0, 4'b0000);
        step_chk(2'b01, 2'd2, 1, "dn_still_held", 0, 0, 0, 0, 4'b0000);
        step(2'b00, 2'd2, 1);
        step_chk(2'b10, 2'd2, 1, "up_after_both", 0, 1, 0, 0, 4'b0000);

        // Tick deferred by adjust cycles; prescaler keeps running
        do_reset(2'b00, 2'd0, "rst_defer");
        step(2'b00, 2'd0, 1);
        step(2'b10, 2'd0, 1);
        step(2'b00, 2'd0, 1);
        step(2'b10, 2'd0, 1);
        step(2'b00, 2'd0, 1);
        step(2'b10, 2'd0, 1);
        step(2'b00, 2'd0, 1);
        step(2'b10, 2'd0, 1);
        step_chk(2'b00, 2'd0, 1, "preload_4", 0, 0, 0, 4, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "tick_to_5", 0, 0, 0, 5, 4'b0000);
        step(2'b00, 2'd0, 8);
        step_chk(2'b00, 2'd0, 1, "before_tick", 0, 0, 0, 5, 4'b0000);
        step_chk(2'b10, 2'd0, 1, "adj_on_tick", 0, 0, 0, 6, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "deferred_tick", 0, 0, 0, 7, 4'b0000);
        step(2'b00, 2'd0, 7);
        step_chk(2'b00, 2'd0, 1, "presc_pre", 0, 0, 0, 7, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "presc_free", 0, 0, 0, 8, 4'b0000);
        step(2'b00, 2'd0, 9);
        step_chk(2'b10, 2'd0, 1, "dbl_up", 0, 0, 0, 9, 4'b0000);
        step_chk(2'b01, 2'd0, 1, "dbl_dn", 0, 0, 0, 8, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "dbl_deferred", 0, 0, 0, 9, 4'b0000);
        step(2'b00, 2'd0, 7);
        step_chk(2'b00, 2'd0, 1, "dbl_next_tick", 0, 0, 0, 10, 4'b0000);

        // Mid-operation reset, then full cascade from 23:59:59.99
        do_reset(2'b00, 2'd3, "rst_midop");
        step_chk(2'b01, 2'd3, 1, "pre_hour", 23, 0, 0, 0, 4'b0000);
        step(2'b00, 2'd3, 1);
        step_chk(2'b01, 2'd2, 1, "pre_min", 23, 59, 0, 0, 4'b0000);
        step(2'b00, 2'd2, 1);
        step_chk(2'b01, 2'd1, 1, "pre_sec", 23, 59, 59, 0, 4'b0000);
        step(2'b00, 2'd1, 1);
        step_chk(2'b01, 2'd0, 1, "pre_msec", 23, 59, 59, 99, 4'b0000);
        step(2'b00, 2'd0, 1);
        step_chk(2'b00, 2'd0, 1, "before_roll", 23, 59, 59, 99, 4'b0000);
        step_chk(2'b00, 2'd0, 1, "rollover", 0, 0, 0, 0, 4'b0000);
        step_chk(2'b00, 2'd0, 10, "after_roll", 0, 0, 0, 1, 4'b0000);

        // Button held through reset release counts as one press
        do_reset(2'b10, 2'd2, "rst_held_btn");
        step_chk(2'b10, 2'd2, 1, "press_at_release", 0, 1, 0, 0, 4'b0000);
        step_chk(2'b10, 2'd2, 5, "still_held", 0, 1, 0, 0, 4'b0000);
        step(2'b00, 2'd2, 1);

        // Blink on the selected field; a press restarts the phase
        do_reset(2'b00, 2'd1, "rst_blink");
        step_chk(2'b00, 2'd1, 245, "blink_off", 0, 0, 0, 24, 4'b0000);
        step_chk(2'b00, 2'd1, 10, "blink_on", 0, 0, 0, 25, BLINK_SEC);
        step_chk(2'b10, 2'd1, 2, "blink_press", 0, 0, 1, 25, 4'b0000);
        step(2'b00, 2'd1, 1);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL sb_leftover: observed %0d queued, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
